// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared FSM encoding, default widths and helpers for the memory responder
package mem_responder_pkg;
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
    localparam int ADDR_W_DEF = 30;
    localparam int DATA_W_DEF = 32;
    function automatic int max_int(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/mem_responder_sram_sp.sv
// mem_responder_sram_sp: single-port synchronous word array with registered read
module mem_responder_sram_sp #(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_W = 32,
  parameter string INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);
  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: word memory answering read/write requests after a fixed latency with a ready pulse
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH_LOG2 = 10,
    parameter int RD_LAT = 8,
    parameter int WR_LAT = 8,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              proc_reset_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              busy,
    output logic              proto_err
);
    localparam int CNT_W = $clog2(max_int(RD_LAT, WR_LAT) + 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LAT - 1);
    state_t state;
    logic [CNT_W-1:0] cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic op_wr;
    logic req, idle, lat1, fire, fire_wr;
    logic [DEPTH_LOG2-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    assign req = mem_read | mem_write;
    assign idle = state == S_IDLE;
    assign lat1 = mem_write ? (WR_LAT == 1) : (RD_LAT == 1);
    // the array access happens on the edge that enters RESP; a single-cycle latency uses the live request
    assign fire = proc_reset_n && ((idle && req && lat1) || (state == S_BUSY && cnt == CNT_W'(1)));
    assign fire_wr = idle ? mem_write : op_wr;
    assign sram_addr = idle ? mem_addr[DEPTH_LOG2-1:0] : addr_q[DEPTH_LOG2-1:0];
    assign sram_wdata = idle ? mem_wdata : wdata_q;
    mem_responder_sram_sp #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .DATA_W(DATA_W),
        .INIT_FILE(INIT_FILE)
    ) u_sram (
        .clk(clk),
        .rst_n(proc_reset_n),
        .we(fire && fire_wr),
        .re(fire && !fire_wr),
        .addr(sram_addr),
        .wdata(sram_wdata),
        .rdata(mem_rdata)
    );
    always_ff @(posedge clk) begin
        if (!proc_reset_n) begin
            state <= S_IDLE;
            cnt <= '0;
            mem_ready <= 1'b0;
            busy <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: if (req) begin
                    addr_q <= mem_addr;
                    wdata_q <= mem_wdata;
                    op_wr <= mem_write;
                    cnt <= mem_write ? WR_LOAD : RD_LOAD;
                    state <= lat1 ? S_RESP : S_BUSY;
                    mem_ready <= lat1;
                    busy <= 1'b1;
                    if (mem_read && mem_write) proto_err <= 1'b1;
                end
                S_BUSY: begin
                    cnt <= cnt - 1'b1;
                    if (!req || mem_addr != addr_q) proto_err <= 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= S_RESP;
                        mem_ready <= 1'b1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                    mem_ready <= 1'b0;
                    busy <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed and randomized checks of two responders (latency 8 and latency 1)
module tb_mem_responder;
    logic clk = 1'b0;
    logic rstn [2];
    logic rd [2];
    logic wr [2];
    logic [29:0] ad [2];
    logic [31:0] wd [2];
    logic [31:0] rdata [2];
    logic ready [2];
    logic busy [2];
    logic perr [2];
    logic [31:0] mdl [2][1024];
    logic [31:0] last [2];
    logic pe [2];
    bit written [2][16];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_responder u8 (
        .clk(clk), .proc_reset_n(rstn[0]), .mem_read(rd[0]), .mem_write(wr[0]),
        .mem_addr(ad[0]), .mem_wdata(wd[0]), .mem_rdata(rdata[0]), .mem_ready(ready[0]),
        .busy(busy[0]), .proto_err(perr[0])
    );
    mem_responder #(.RD_LAT(1), .WR_LAT(1)) u1 (
        .clk(clk), .proc_reset_n(rstn[1]), .mem_read(rd[1]), .mem_write(wr[1]),
        .mem_addr(ad[1]), .mem_wdata(wd[1]), .mem_rdata(rdata[1]), .mem_ready(ready[1]),
        .busy(busy[1]), .proto_err(perr[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int s);
        rstn[s] = 1'b0;
        rd[s] = 1'b0;
        wr[s] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", {31'b0, ready[s]}, 0);
        chk("reset_rdata", rdata[s], 0);
        chk("reset_busy", {31'b0, busy[s]}, 0);
        chk("reset_perr", {31'b0, perr[s]}, 0);
        rstn[s] = 1'b1;
        pe[s] = 1'b0;
        last[s] = '0;
    endtask

    task automatic idle(input int s);
        rd[s] = 1'b0;
        wr[s] = 1'b0;
    endtask

    // present a request now and follow it to completion; the request stays asserted on return
    task automatic txn(input int s, input bit w, input bit r, input logic [29:0] a,
                       input logic [31:0] d, input int glitch);
        int lat, n;
        lat = (s == 1) ? 1 : 8;
        rd[s] = r;
        wr[s] = w;
        ad[s] = a;
        wd[s] = d;
        if (w && r) pe[s] = 1'b1;
        if (glitch > 0) pe[s] = 1'b1;
        n = 0;
        while (n < lat + 4) begin
            @(posedge clk);
            #1;
            n++;
            if (ready[s]) break;
            if (n == 1) chk("busy_busy", {31'b0, busy[s]}, 1);
            if (n == glitch) ad[s] = a ^ 30'h1;
        end
        chk("latency", 32'(n), 32'(lat));
        if (w) mdl[s][a[9:0]] = d;
        else last[s] = mdl[s][a[9:0]];
        chk("rdata", rdata[s], last[s]);
        chk("busy_resp", {31'b0, busy[s]}, 1);
        chk("perr", {31'b0, perr[s]}, {31'b0, pe[s]});
        @(posedge clk);
        #1;
        chk("pulse_width", {31'b0, ready[s]}, 0);
        chk("busy_idle", {31'b0, busy[s]}, 0);
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            rstn[s] = 1'b0;
            rd[s] = 1'b0;
            wr[s] = 1'b0;
            ad[s] = '0;
            wd[s] = '0;
        end
        do_reset(0);
        do_reset(1);
        // basic write then read
        txn(0, 1, 0, 30'h10, 32'hDEADBEEF, 0);
        idle(0);
        @(posedge clk); #1;
        txn(0, 0, 1, 30'h10, 32'h0, 0);
        idle(0);
        // writeback then refill issued with no idle gap
        txn(0, 1, 0, 30'h35, 32'hCAFE0035, 0);
        txn(0, 1, 0, 30'h25, 32'h25252525, 0);
        txn(0, 0, 1, 30'h35, 32'h0, 0);
        idle(0);
        repeat (10) begin
            @(posedge clk); #1;
            chk("no_dup_accept", {31'b0, ready[0]}, 0);
        end
        txn(0, 0, 1, 30'h3FFF_FC25, 32'h0, 0);
        idle(0);
        // latency-1 back-to-back traffic
        txn(1, 1, 0, 30'h0, 32'h01234567, 0);
        txn(1, 1, 0, 30'h1, 32'h89ABCDEF, 0);
        txn(1, 0, 1, 30'h0, 32'h0, 0);
        txn(1, 0, 1, 30'h1, 32'h0, 0);
        txn(1, 1, 1, 30'h2, 32'h77, 0);
        idle(1);
        // simultaneous read and write counts as a write and flags an error
        txn(0, 1, 1, 30'h3, 32'h55, 0);
        txn(0, 0, 1, 30'h3, 32'h0, 0);
        idle(0);
        do_reset(0);
        // address changes while the transaction is in flight
        txn(0, 0, 1, 30'h10, 32'h0, 3);
        idle(0);
        do_reset(0);
        // reset during a write aborts it
        txn(0, 1, 0, 30'h7, 32'h11111111, 0);
        wr[0] = 1'b1;
        ad[0] = 30'h7;
        wd[0] = 32'h22222222;
        repeat (5) @(posedge clk);
        #1;
        rstn[0] = 1'b0;
        idle(0);
        repeat (4) begin
            @(posedge clk); #1;
            chk("abort_ready", {31'b0, ready[0]}, 0);
        end
        rstn[0] = 1'b1;
        pe[0] = 1'b0;
        last[0] = '0;
        chk("abort_rdata", rdata[0], 0);
        txn(0, 0, 1, 30'h7, 32'h0, 0);
        idle(0);
        // randomized traffic against the array model
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 40; i++) begin
                int ix, gap;
                bit w;
                logic [29:0] a;
                ix = $urandom_range(0, 15);
                w = 1'($urandom_range(0, 1));
                if (!written[s][ix]) w = 1'b1;
                a = {20'($urandom), 6'd0, 4'(ix)};
                txn(s, w, !w, a, $urandom, 0);
                if (w) written[s][ix] = 1'b1;
                gap = $urandom_range(0, 2);
                if (gap > 0) begin
                    idle(s);
                    repeat (gap) @(posedge clk);
                    #1;
                end
            end
            idle(s);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
